// File: rtl/flit_assembler_2_pkg.sv
// Shared flit field positions and assembler state encoding.
// Bit positions are offsets down from the flit MSB so any flit width works.
package flit_assembler_2_pkg;

  localparam int VALID_OFS = 1;
  localparam int HEAD_OFS  = 2;
  localparam int TAIL_OFS  = 3;
  localparam int VC_OFS    = 4;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    EXPECT_HEAD,
    EXPECT_TAIL
  } asm_state_t;

endpackage

// File: rtl/flit_assembler_2_fifo.sv
// pkt_fifo_2: generic 2-deep valid/ready FIFO.
// Ports: in_data/in_valid/in_ready push side, out_data/out_valid/out_ready pop side.
module pkt_fifo_2 #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flit_assembler_2.sv
// Assembles head/tail flit pairs into packets, buffered in a 2-entry FIFO.
// Ports: flit_in/flit_valid_in/flit_ready_out in, data_out/valid_out/ready_in out, error_out, drop_count.
module flit_assembler_2
  import flit_assembler_2_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_PKT/2-1:0]  flit_in,
  input  logic                    flit_valid_in,
  output logic                    flit_ready_out,
  output logic [WIDTH_PKT-1:0]    data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    error_out,
  output logic [7:0]              drop_count
);

  localparam int WIDTH_FLIT = WIDTH_PKT / 2;
  localparam int V_BIT      = WIDTH_FLIT - VALID_OFS;
  localparam int H_BIT      = WIDTH_FLIT - HEAD_OFS;
  localparam int T_BIT      = WIDTH_FLIT - TAIL_OFS;
  localparam int VC_MSB     = WIDTH_FLIT - VC_OFS;

  if (WIDTH_FLIT < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) begin : g_width_chk
    $error("flit too narrow for control, VC and destination fields");
  end

  asm_state_t            state;
  asm_state_t            state_n;
  logic [WIDTH_FLIT-1:0] head_reg;
  logic [WIDTH_FLIT-1:0] head_n;
  logic                  push;
  logic [WIDTH_PKT-1:0]  push_data;
  logic [1:0]            drop_inc;
  logic [8:0]            drop_sum;
  logic                  accept;
  logic                  f_valid;
  logic                  f_head;
  logic                  f_tail;
  logic                  vc_match;

  assign accept   = flit_valid_in && flit_ready_out;
  assign f_valid  = flit_in[V_BIT];
  assign f_head   = flit_in[H_BIT];
  assign f_tail   = flit_in[T_BIT];
  assign vc_match = (flit_in[VC_MSB -: VC_ADDRESS_WIDTH] ==
                     head_reg[VC_MSB -: VC_ADDRESS_WIDTH]);

  always_comb begin
    state_n   = state;
    head_n    = head_reg;
    push      = 1'b0;
    push_data = '0;
    drop_inc  = 2'd0;
    if (accept && f_valid) begin
      unique case (state)
        EXPECT_HEAD: begin
          unique case (1'b1)
            !f_head: begin
              drop_inc = 2'd1;
            end
            f_head && f_tail: begin
              push      = 1'b1;
              push_data = {flit_in, {WIDTH_FLIT{1'b0}}};
            end
            f_head && !f_tail: begin
              head_n  = flit_in;
              state_n = EXPECT_TAIL;
            end
          endcase
        end
        EXPECT_TAIL: begin
          unique case (1'b1)
            // New head abandons the stored one, then starts afresh.
            f_head && f_tail: begin
              drop_inc  = 2'd1;
              push      = 1'b1;
              push_data = {flit_in, {WIDTH_FLIT{1'b0}}};
              state_n   = EXPECT_HEAD;
            end
            f_head && !f_tail: begin
              drop_inc = 2'd1;
              head_n   = flit_in;
            end
            !f_head && f_tail && vc_match: begin
              push      = 1'b1;
              push_data = {head_reg, flit_in};
              state_n   = EXPECT_HEAD;
            end
            !f_head && !(f_tail && vc_match): begin
              drop_inc = 2'd2;
              state_n  = EXPECT_HEAD;
            end
          endcase
        end
        default: state_n = EXPECT_HEAD;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EXPECT_HEAD;
      head_reg   <= '0;
      error_out  <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state    <= state_n;
      head_reg <= head_n;
      if (drop_inc != 2'd0) begin
        error_out  <= 1'b1;
        drop_count <= drop_sum[8] ? DROP_MAX : drop_sum[7:0];
      end
    end
  end

  pkt_fifo_2 #(
    .WIDTH (WIDTH_PKT)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (push_data),
    .in_valid  (push),
    .in_ready  (flit_ready_out),
    .out_data  (data_out),
    .out_valid (valid_out),
    .out_ready (ready_in)
  );

endmodule

// File: tb/tb_flit_assembler_2.sv
// Randomised and directed bench for flit_assembler_2 against a queue model.
// Outputs are compared with the model at every falling edge.
module tb_flit_assembler_2;

  logic        clk;
  logic        rst_n;
  logic [17:0] flit_in;
  logic        flit_valid_in;
  logic        flit_ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        error_out;
  logic [7:0]  drop_count;

  int total;
  int bad;

  flit_assembler_2 #(
    .WIDTH_PKT        (36),
    .VC_ADDRESS_WIDTH (1),
    .ADDRESS_WIDTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .flit_ready_out (flit_ready_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .error_out      (error_out),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: packet queue, pending head, drop counter.
  logic [35:0] mq[$];
  bit          m_in_tail;
  logic [17:0] m_head;
  int          m_drop;
  bit          m_err;
  int          mpops;
  bit          m_acc;
  bit          m_pop;
  logic [17:0] m_f;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(bit v, bit h, bit t, bit vc,
                                     logic [13:0] p);
    return {v, h, t, vc, p};
  endfunction

  function automatic void mdrop(int n);
    m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
    m_err  = 1'b1;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_in_tail = 1'b0;
    m_head    = '0;
    m_drop    = 0;
    m_err     = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_acc = flit_valid_in && (mq.size() < 2);
      m_pop = (mq.size() > 0) && ready_in;
      m_f   = flit_in;
      if (m_pop) begin
        void'(mq.pop_front());
        mpops++;
      end
      if (m_acc && m_f[17]) begin
        if (m_f[16]) begin
          if (m_in_tail) mdrop(1);
          if (m_f[15]) begin
            mq.push_back({m_f, 18'd0});
            m_in_tail = 1'b0;
          end else begin
            m_head    = m_f;
            m_in_tail = 1'b1;
          end
        end else if (!m_in_tail) begin
          mdrop(1);
        end else begin
          if (m_f[15] && m_f[14] == m_head[14])
            mq.push_back({m_head, m_f});
          else
            mdrop(2);
          m_in_tail = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_out", valid_out, mq.size() > 0);
      if (mq.size() > 0) chk("data_out", data_out, mq[0]);
      chk("flit_ready_out", flit_ready_out, mq.size() < 2);
      chk("drop_count", drop_count, m_drop);
      chk("error_out", error_out, m_err);
    end
  end

  task automatic send(input logic [17:0] f);
    int n;
    @(negedge clk);
    flit_in       = f;
    flit_valid_in = 1'b1;
    n = 0;
    while (!flit_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 200, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    flit_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    flit_valid_in = 1'b0;
    ready_in      = 1'b1;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_data", data_out, 36'd0);
    chk("rst_ready", flit_ready_out, 1'b1);
    chk("rst_drop", drop_count, 8'd0);
    chk("rst_err", error_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int r;
    total         = 0;
    bad           = 0;
    mpops         = 0;
    rst_n         = 1'b0;
    flit_in       = '0;
    flit_valid_in = 1'b0;
    ready_in      = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic pair, valid one cycle after tail accept.
    send(18'h30001);
    send(18'h28002);
    chk("pair_pre_valid", valid_out, 1'b0);
    @(posedge clk);
    #1;
    chk("pair_valid", valid_out, 1'b1);
    chk("pair_data", data_out, {18'h30001, 18'h28002});
    idle();

    // Invalid flit mid-packet is ignored; tail lacking tail bit drops both.
    send(18'h30001);
    send(18'h10005);
    send(18'h28002);
    @(posedge clk);
    #1;
    chk("inv_data", data_out, {18'h30001, 18'h28002});
    send(18'h30003);
    send(18'h20002);
    idle();
    repeat (2) @(negedge clk);
    chk("notail_drop", drop_count, 8'd2);

    // Backpressure with three packets.
    do_reset();
    ready_in = 1'b0;
    p0 = mpops;
    send(mk(1, 1, 0, 0, 14'h0011));
    send(mk(1, 0, 1, 0, 14'h0012));
    send(mk(1, 1, 0, 0, 14'h0021));
    send(mk(1, 0, 1, 0, 14'h0022));
    fork
      begin
        send(mk(1, 1, 0, 0, 14'h0031));
        send(mk(1, 0, 1, 0, 14'h0032));
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_low", flit_ready_out, 1'b0);
        chk("bp_valid", valid_out, 1'b1);
        ready_in = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("bp_pops", mpops - p0, 3);
    chk("bp_empty", valid_out, 1'b0);

    // Head, head, tail.
    do_reset();
    send(mk(1, 1, 0, 0, 14'h0aaa));
    send(mk(1, 1, 0, 0, 14'h0bbb));
    send(mk(1, 0, 1, 0, 14'h0ccc));
    @(posedge clk);
    #1;
    chk("hht_data", data_out,
        {mk(1, 1, 0, 0, 14'h0bbb), mk(1, 0, 1, 0, 14'h0ccc)});
    idle();
    repeat (2) @(negedge clk);
    chk("hht_drop", drop_count, 8'd1);
    chk("hht_err", error_out, 1'b1);

    // Orphan tails and saturation.
    do_reset();
    send(mk(1, 0, 1, 0, 14'h0001));
    idle();
    repeat (2) @(negedge clk);
    chk("orphan_drop", drop_count, 8'd1);
    chk("orphan_nopkt", valid_out, 1'b0);
    for (int i = 0; i < 299; i++) send(mk(1, 0, 1, 0, 14'(i)));
    send(mk(1, 1, 0, 0, 14'h0100));
    send(mk(1, 0, 1, 1, 14'h0101));
    idle();
    repeat (2) @(negedge clk);
    chk("sat_drop", drop_count, 8'd255);
    chk("sat_err", error_out, 1'b1);

    // VC mismatch, then a normal pair.
    do_reset();
    send(mk(1, 1, 0, 0, 14'h0040));
    send(mk(1, 0, 1, 1, 14'h0041));
    idle();
    repeat (2) @(negedge clk);
    chk("vc_drop", drop_count, 8'd2);
    chk("vc_nopkt", valid_out, 1'b0);
    send(mk(1, 1, 0, 1, 14'h0050));
    send(mk(1, 0, 1, 1, 14'h0051));
    @(posedge clk);
    #1;
    chk("vc_after", data_out,
        {mk(1, 1, 0, 1, 14'h0050), mk(1, 0, 1, 1, 14'h0051)});
    idle();

    // Asynchronous reset with a packet queued and a head pending.
    do_reset();
    ready_in = 1'b0;
    send(mk(1, 1, 1, 0, 14'h0060));
    send(mk(1, 1, 0, 0, 14'h0061));
    idle();
    @(negedge clk);
    chk("mid_valid_pre", valid_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", valid_out, 1'b0);
    chk("mid_drop", drop_count, 8'd0);
    chk("mid_ready", flit_ready_out, 1'b1);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    send(mk(1, 1, 0, 0, 14'h0070));
    send(mk(1, 0, 1, 0, 14'h0071));
    @(posedge clk);
    #1;
    chk("mid_after", data_out,
        {mk(1, 1, 0, 0, 14'h0070), mk(1, 0, 1, 0, 14'h0071)});
    idle();
    repeat (2) @(negedge clk);
    chk("mid_after_drop", drop_count, 8'd0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 19);
      flit_valid_in = ($urandom_range(0, 3) != 0);
      ready_in      = ($urandom_range(0, 3) != 0);
      flit_in = mk($urandom_range(0, 7) != 0,
                   r < 11,
                   (r >= 8 && r < 18),
                   $urandom_range(0, 9) == 0,
                   14'($urandom));
    end
    idle();
    ready_in = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
